// File: rtl/rom_stream_reader.sv
// Purpose : burst reader for a dual-port ROM; streams word pairs {q_b,q_a} from base_addr upward.
// Latency : first out_valid 2 clk after the accepted start edge, then one pair per clk while out_ready=1.
// Backpres: a 2-entry output FIFO absorbs stalls; reads are throttled so the FIFO never overflows.
//
// Ports:
//   clk, rst               single clock, asynchronous active-high reset
//   start, base_addr,      one-cycle burst request (ignored while busy); num_pairs=0 gives
//   num_pairs              only a done pulse on the next cycle
//   addr_a, addr_b         registered ROM addresses (ptr, ptr+1, modulo 2**addr_width)
//   q_a, q_b               ROM data, valid one clk after the addresses
//   out_data, out_valid,   FIFO head {q_b,q_a} with valid/ready handshake
//   out_ready
//   busy, done             burst in progress; one-cycle pulse at burst end
// Optional: define ROM_STREAM_CHECKSUM_EN to add output checksum (XOR of all popped pairs).
module rom_stream_reader #(
  parameter int data_width = 8,
  parameter int addr_width = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [addr_width-1:0]   base_addr,
  input  logic [addr_width-1:0]   num_pairs,
  output logic [addr_width-1:0]   addr_a,
  output logic [addr_width-1:0]   addr_b,
  input  logic [data_width-1:0]   q_a,
  input  logic [data_width-1:0]   q_b,
  output logic [2*data_width-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
`ifdef ROM_STREAM_CHECKSUM_EN
  output logic [2*data_width-1:0] checksum,
`endif
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [addr_width-1:0]   ptr;
  logic [addr_width-1:0]   rem;        // reads still to be issued
  logic                    inflight;   // a read was issued on the last edge; data lands on the next
  logic                    zero_done;  // done pulse for a zero-length request

  logic [2*data_width-1:0] fifo_mem [2];
  logic                    wr_idx, rd_idx;
  logic [1:0]              count;

  logic                    push, pop, issue, final_pop, start_ok, start_zero;
  logic [2:0]              occ;

  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_mem[rd_idx];
  assign pop       = out_valid & out_ready;
  assign push      = inflight;

  // Occupancy after this cycle's pop plus the read already in flight. Counting the
  // departing pair keeps one pair per clock with out_ready high, and still leaves room
  // for the data of a read issued now.
  assign occ        = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == FETCH) && (occ < 3'd2);
  assign final_pop  = (state == DRAIN) && pop && (count == 2'd1) && !inflight;
  assign start_ok   = (state == IDLE) && start && (num_pairs != '0);
  assign start_zero = (state == IDLE) && start && (num_pairs == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = zero_done | final_pop;
    case (state)
      IDLE:    if (start_ok) state_nxt = FETCH;
      FETCH:   if (issue && (rem == addr_width'(1))) state_nxt = DRAIN;
      DRAIN:   if (final_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read issue: address registers, pointer and remaining count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      rem       <= '0;
      addr_a    <= '0;
      addr_b    <= '0;
      inflight  <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      inflight  <= issue;
      zero_done <= start_zero;
      if (start_ok) begin
        ptr <= base_addr;
        rem <= num_pairs;
      end else if (issue) begin
        addr_a <= ptr;
        addr_b <= ptr + addr_width'(1);
        ptr    <= ptr + addr_width'(2);
        rem    <= rem - addr_width'(1);
      end
    end
  end

  // Two-entry output FIFO; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_idx      <= 1'b0;
      rd_idx      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_idx] <= {q_b, q_a};
        wr_idx           <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef ROM_STREAM_CHECKSUM_EN
  // Cleared on any accepted start; otherwise only popped pairs change it, so it holds
  // from the done pulse until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        checksum <= '0;
    else if (start_ok | start_zero) checksum <= '0;
    else if (pop)                   checksum <= checksum ^ out_data;
  end
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
module tb_rom_stream_reader;
  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic [AW-1:0] base_addr, num_pairs, addr_a, addr_b;
  logic [DW-1:0] q_a, q_b;
  logic [2*DW-1:0] out_data;
  logic          out_valid, busy, done;
`ifdef ROM_STREAM_CHECKSUM_EN
  logic [2*DW-1:0] checksum;
`endif

  int checks = 0;
  int failures = 0;
  logic [2*DW-1:0] sb [$];

  always #5 clk = ~clk;

  // ROM model rom[i] = i, data valid one clock after the registered address.
  assign q_a = addr_a;
  assign q_b = addr_b;

  rom_stream_reader #(.data_width(DW), .addr_width(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_pairs(num_pairs),
    .addr_a(addr_a), .addr_b(addr_b), .q_a(q_a), .q_b(q_b),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy),
`ifdef ROM_STREAM_CHECKSUM_EN
    .checksum(checksum),
`endif
    .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid head must match the oldest expected pair (also proves
  // stability while stalled); it retires when the handshake completes.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_pair observed=%0h expected=none", out_data);
      end
      if (sb.size() > 0) begin
        check("pair", 32'(out_data), 32'(sb[0]));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [AW-1:0] base, input logic [AW-1:0] n);
    start     = 1'b1;
    base_addr = base;
    num_pairs = n;
    step();
    start     = 1'b0;
  endtask

  task automatic expect_pairs(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = base + AW'(2 * i);
      b = a + AW'(1);
      sb.push_back({b, a});
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy && !out_valid && sb.size() == 0) break;
    end
    checks++;
    assert (k < 200) else begin
      failures++;
      $error("FAIL %s_timeout observed=%0d expected=<200 cycles", tag, k);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; base_addr = '0; num_pairs = '0;
    step();
    check("rst_addr_a", 32'(addr_a), 0);
    check("rst_addr_b", 32'(addr_b), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    step();
    rst = 1'b0;
    step();

    // Basic burst: latency, throughput and done placement.
    expect_pairs(8'h10, 4);
    go(8'h10, 8'd4);
    @(negedge clk); check("b1_valid_c0", 32'(out_valid), 0); check("b1_busy", 32'(busy), 1);
    @(negedge clk); check("b1_valid_c1", 32'(out_valid), 0);
    @(negedge clk); check("b1_valid_c2", 32'(out_valid), 1); check("b1_done_c2", 32'(done), 0);
    @(negedge clk); check("b1_valid_c3", 32'(out_valid), 1);
    @(negedge clk); check("b1_valid_c4", 32'(out_valid), 1); check("b1_done_c4", 32'(done), 0);
    @(negedge clk); check("b1_valid_c5", 32'(out_valid), 1); check("b1_done_c5", 32'(done), 1);
    @(negedge clk);
    check("b1_end_valid", 32'(out_valid), 0);
    check("b1_end_busy", 32'(busy), 0);
    check("b1_end_done", 32'(done), 0);
    check("b1_sb_empty", 32'(sb.size()), 0);
`ifdef ROM_STREAM_CHECKSUM_EN
    check("b1_checksum", 32'(checksum), 32'h0000);
`endif
    step();

    // Address wrap.
    expect_pairs(8'hFF, 2);
    go(8'hFF, 8'd2);
    wait_idle("wrap");
    check("wrap_sb_empty", 32'(sb.size()), 0);
`ifdef ROM_STREAM_CHECKSUM_EN
    check("wrap_checksum", 32'(checksum), 32'h02FE);
`endif
    step();

    // Backpressure: ready pattern 1,0,0 repeating.
    expect_pairs(8'h20, 6);
    go(8'h20, 8'd6);
    for (int i = 0; i < 120 && (busy || out_valid || sb.size() != 0); i++) begin
      out_ready = (i % 3 == 0);
      step();
    end
    out_ready = 1'b1;
    check("stall_sb_empty", 32'(sb.size()), 0);
    check("stall_busy", 32'(busy), 0);
    step();

    // Reset in the cycle after the second read issues.
    expect_pairs(8'h30, 4);
    go(8'h30, 8'd4);
    step();
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_addr_a", 32'(addr_a), 0);
    check("mid_rst_addr_b", 32'(addr_b), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    sb.delete();
    step();
    step();
    rst = 1'b0;
    step();
    expect_pairs(8'h40, 1);
    go(8'h40, 8'd1);
    @(negedge clk); check("r1_valid_c0", 32'(out_valid), 0);
    @(negedge clk); check("r1_valid_c1", 32'(out_valid), 0);
    @(negedge clk); check("r1_valid_c2", 32'(out_valid), 1); check("r1_done_c2", 32'(done), 1);
    @(negedge clk); check("r1_end_busy", 32'(busy), 0); check("r1_sb_empty", 32'(sb.size()), 0);
    step();

    // Start while busy must be ignored.
    expect_pairs(8'h50, 3);
    go(8'h50, 8'd3);
    step();
    go(8'h00, 8'd5);
    wait_idle("busy_start");
    check("busy_start_sb_empty", 32'(sb.size()), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_start_quiet", 32'({busy, out_valid}), 0);
    end
    step();

    // Zero-length request.
    go(8'h60, 8'd0);
    check("zero_busy", 32'(busy), 0);
    @(negedge clk); check("zero_done_pulse", 32'(done), 1); check("zero_valid", 32'(out_valid), 0);
    @(negedge clk); check("zero_done_clear", 32'(done), 0); check("zero_valid2", 32'(out_valid), 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rom_stream_reader.md
ROM_STREAM_READER -- requirements
Module: rom_stream_reader

Interface
REQ-001 The block SHALL have parameter data_width, default 8, meaning ROM word width in bits.
REQ-002 The block SHALL have parameter addr_width, default 8, meaning ROM address width in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, single-cycle request to begin a burst.
REQ-006 The block SHALL have port base_addr, input, addr_width, first ROM address of the burst.
REQ-007 The block SHALL have port num_pairs, input, addr_width, number of word pairs to read.
REQ-008 The block SHALL have port addr_a, output, addr_width, registered ROM port-A address.
REQ-009 The block SHALL have port addr_b, output, addr_width, registered ROM port-B address.
REQ-010 The block SHALL have port q_a, input, data_width, ROM port-A data, valid one clk after addr_a.
REQ-011 The block SHALL have port q_b, input, data_width, ROM port-B data, valid one clk after addr_b.
REQ-012 The block SHALL have port out_data, output, 2*data_width, pair {q_b,q_a}.
REQ-013 The block SHALL have port out_valid, output, 1, out_data holds a pair.
REQ-014 The block SHALL have port out_ready, input, 1, downstream accepts the pair.
REQ-015 The block SHALL have port busy, output, 1, burst in progress.
REQ-016 The block SHALL have port done, output, 1, one-cycle pulse at burst end.

Function
REQ-017 The block SHALL implement FSM states IDLE, FETCH, DRAIN.
REQ-018 In IDLE, on start=1 with num_pairs>0, the block SHALL latch base_addr into ptr and num_pairs into a remaining-issue counter and enter FETCH.
REQ-019 In IDLE, on start=1 with num_pairs=0, the block SHALL stay in IDLE, emit no data, and pulse done in the next cycle.
REQ-020 start SHALL be ignored while busy=1; busy SHALL be 1 in FETCH and DRAIN.
REQ-021 In FETCH, a read SHALL be issued in any cycle where FIFO occupancy plus in-flight reads is less than 2: addr_a<=ptr, addr_b<=ptr+1, ptr<=ptr+2, remaining-issue counter decremented.
REQ-022 All address arithmetic SHALL be modulo 2**addr_width; ptr=2**addr_width-1 gives addr_b=0.
REQ-023 q_a and q_b SHALL be written into a 2-entry FIFO on the edge one cycle after the issuing edge (fixed 1-cycle ROM latency).
REQ-024 out_valid SHALL equal FIFO non-empty; out_data SHALL be the FIFO head; a pair pops when out_valid and out_ready are both 1.
REQ-025 A FIFO push and pop in the same cycle SHALL both take effect and leave occupancy unchanged.
REQ-026 FETCH SHALL go to DRAIN when the last read issues; DRAIN SHALL go to IDLE when the final pair pops, and done SHALL pulse in that pop cycle.
REQ-027 With out_ready held at 1, the first out_valid SHALL occur 2 cycles after the start edge, and one pair SHALL be delivered per cycle.
REQ-028 out_data SHALL stay stable while out_valid=1 and out_ready=0, and the FIFO SHALL never overflow.

Reset
REQ-029 rst=1 SHALL immediately force: state IDLE; addr_a, addr_b, ptr, and counters to 0; FIFO empty; out_valid, busy, and done to 0.
REQ-030 On rst mid-burst, any in-flight read SHALL be discarded; the first start after rst deasserts SHALL behave as from power-up.

Configuration
REQ-031 With macro ROM_STREAM_CHECKSUM_EN defined, the block SHALL add output checksum[2*data_width-1:0], cleared on rst and on accepted start, XOR-accumulated with each popped out_data, and held stable from the done pulse until the next start.
REQ-032 Without ROM_STREAM_CHECKSUM_EN, the checksum port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Model the ROM as rom[i]=i; base_addr=0x10, num_pairs=4, out_ready=1 -> out_data 0x1110, 0x1312, 0x1514, 0x1716 on consecutive cycles, first out_valid 2 cycles after start, done with the last pair.
REQ-034 base_addr=0xFF, num_pairs=2 -> pairs 0x00FF, 0x0201 (address wrap).
REQ-035 num_pairs=6 with out_ready toggled 1,0,0,1,... -> all 6 pairs delivered in order with none lost or duplicated, out_data stable while stalled, occupancy never above 2.
REQ-036 Assert rst at the cycle after the second pair issues -> all outputs 0 at once; a new start with base 0x40, num_pairs=1 -> single pair 0x4140.
REQ-037 Pulse start while busy, and separately start with num_pairs=0 -> the busy start is ignored and the burst is unaffected; the zero-length start gives done one cycle later with no out_valid.
REQ-038 With ROM_STREAM_CHECKSUM_EN defined, repeat REQ-033 -> checksum=0x1110^0x1312^0x1514^0x1716=0x0000.
